// File: rtl/vend_ctrl_param_if.sv
// Customer-side handshake bundle of the vending controller.
// The master drives the customer requests; the slave (controller) drives the results.
interface vend_ctrl_param_if #(
    parameter int ITEM_W  = 2,
    parameter int MONEY_W = 8
) ();
    logic               start;
    logic               item_valid;
    logic [ITEM_W-1:0]  item_in;
    logic [2:0]         money;
    logic               done_money;
    logic               cancel;
    logic               continue_buy;

    logic               done;
    logic               end_trans;
    logic [MONEY_W-1:0] sum_money;
    logic [MONEY_W-1:0] price;
    logic [ITEM_W-1:0]  item_select;
    logic [MONEY_W-1:0] change;
    logic               change_valid;
    logic               coin_reject;

    modport master (
        output start, item_valid, item_in, money, done_money, cancel, continue_buy,
        input  done, end_trans, sum_money, price, item_select, change, change_valid,
               coin_reject
    );

    modport slave (
        input  start, item_valid, item_in, money, done_money, cancel, continue_buy,
        output done, end_trans, sum_money, price, item_select, change, change_valid,
               coin_reject
    );
endinterface

// File: rtl/vend_ctrl_param.sv
// Vending machine transaction controller: item selection, coin collection with
// overflow protection, dispense, multi-buy credit carry-over, cancel and idle
// timeout. All outputs come from registers or a decode of the state register.
module vend_ctrl_param #(
    parameter int                           N_ITEMS     = 4,
    parameter int                           ITEM_W      = 2,
    parameter int                           MONEY_W     = 8,
    parameter logic [MONEY_W-1:0]           DENOM0      = 5,
    parameter logic [MONEY_W-1:0]           DENOM1      = 10,
    parameter logic [MONEY_W-1:0]           DENOM2      = 20,
    parameter logic [N_ITEMS*MONEY_W-1:0]   PRICE_TABLE = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int                           TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    vend_ctrl_param_if.slave  bus
);

    // Counter only ever needs to reach TIMEOUT-1: the timeout fires on that cycle.
    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        COLLECT  = 3'd2,
        DISPENSE = 3'd3,
        CHANGE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [MONEY_W-1:0] sum_q, sum_d;
    logic [MONEY_W-1:0] price_q, price_d;
    logic [ITEM_W-1:0]  item_q, item_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               rej_q, rej_d;

    logic [MONEY_W-1:0] price_lut [N_ITEMS];
    logic [MONEY_W-1:0] denom;
    logic [MONEY_W:0]   sum_ext;
    logic               in_buy, tmo_hit, abort;
    logic               coin_one, coin_any, coin_ok, item_ok;

    // Unpack the flat price table into a per-item lookup.
    for (genvar i = 0; i < N_ITEMS; i++) begin : g_price
        assign price_lut[i] = PRICE_TABLE[i*MONEY_W +: MONEY_W];
    end

    // Coin decode and credit-acceptance qualification.
    always_comb begin
        denom = '0;
        case (bus.money)
            3'b001:  denom = DENOM0;
            3'b010:  denom = DENOM1;
            3'b100:  denom = DENOM2;
            default: denom = '0;
        endcase
        in_buy   = (state_q == SELECT) || (state_q == COLLECT);
        tmo_hit  = in_buy && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
        // Timeout is treated exactly like a customer cancel.
        abort    = in_buy && (bus.cancel || tmo_hit);
        coin_one = $onehot(bus.money);
        coin_any = |bus.money;
        // One extra bit catches credit overflow so it can be refused, not wrapped.
        sum_ext  = {1'b0, sum_q} + {1'b0, denom};
        coin_ok  = in_buy && !abort && coin_one && !sum_ext[MONEY_W];
        rej_d    = coin_any && !coin_ok;
        item_ok  = (state_q == SELECT) && !abort && bus.item_valid &&
                   (32'(bus.item_in) < N_ITEMS);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        price_d   = price_q;
        item_d    = item_q;
        tmo_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = SELECT;
            end
            SELECT: begin
                if (abort) begin
                    state_d = CHANGE;
                end else if (item_ok) begin
                    state_d = COLLECT;
                    item_d  = bus.item_in;
                    price_d = price_lut[bus.item_in];
                end else if (!coin_ok) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            COLLECT: begin
                if (abort) begin
                    state_d = CHANGE;
                end else if (bus.done_money && (sum_q >= price_q)) begin
                    state_d = DISPENSE;
                end else if (!coin_ok) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            DISPENSE: begin
                sum_d   = sum_q - price_q;
                state_d = bus.continue_buy ? SELECT : CHANGE;
            end
            CHANGE: begin
                sum_d   = '0;
                price_d = '0;
                item_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Accepted coins only occur in SELECT/COLLECT, where sum is otherwise untouched.
        if (coin_ok) sum_d = sum_ext[MONEY_W-1:0];
    end

    // State and datapath registers; reset discards any credit silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sum_q     <= '0;
            price_q   <= '0;
            item_q    <= '0;
            tmo_cnt_q <= '0;
            rej_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            price_q   <= price_d;
            item_q    <= item_d;
            tmo_cnt_q <= tmo_cnt_d;
            rej_q     <= rej_d;
        end
    end

    assign bus.done         = (state_q == DISPENSE);
    assign bus.end_trans    = (state_q == CHANGE);
    assign bus.change_valid = (state_q == CHANGE);
    assign bus.change       = (state_q == CHANGE) ? sum_q : '0;
    assign bus.sum_money    = sum_q;
    assign bus.price        = price_q;
    assign bus.item_select  = item_q;
    assign bus.coin_reject  = rej_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param: a per-cycle vector table for the main
// purchase flows plus hand-written overflow, timeout and reset sequences.
module tb_vend_ctrl_param;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    vend_ctrl_param_if #(.ITEM_W(2), .MONEY_W(8)) bus ();

    vend_ctrl_param dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, iv;
        logic [1:0] item;
        logic [2:0] money;
        logic       dm, cn, cb;
        logic       done, et;
        logic [7:0] sum, price;
        logic [1:0] isel;
        logic [7:0] chg;
        logic       cv, rej;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, iv, input logic [1:0] item, input logic [2:0] money,
                       input logic dm, cn, cb, input logic done, et,
                       input logic [7:0] sum, price, input logic [1:0] isel,
                       input logic [7:0] chg, input logic cv, rej);
        vec_t v;
        v.st = st; v.iv = iv; v.item = item; v.money = money;
        v.dm = dm; v.cn = cn; v.cb = cb;
        v.done = done; v.et = et; v.sum = sum; v.price = price; v.isel = isel;
        v.chg = chg; v.cv = cv; v.rej = rej;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic st, iv, input logic [1:0] item, input logic [2:0] money,
                         input logic dm, cn, cb);
        bus.start = st; bus.item_valid = iv; bus.item_in = item; bus.money = money;
        bus.done_money = dm; bus.cancel = cn; bus.continue_buy = cb;
    endtask

    task automatic idle_in();
        drive(0, 0, 2'd0, 3'b000, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic done, et, input logic [7:0] sum, price,
                       input logic [1:0] isel, input logic [7:0] chg, input logic cv, rej);
        logic [35:0] exp_v, act_v;
        exp_v = {done, et, sum, price, isel, chg, cv, rej};
        act_v = {bus.done, bus.end_trans, bus.sum_money, bus.price, bus.item_select,
                 bus.change, bus.change_valid, bus.coin_reject};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got done=%b et=%b sum=%0d price=%0d isel=%0d chg=%0d cv=%b rej=%b, want done=%b et=%b sum=%0d price=%0d isel=%0d chg=%0d cv=%b rej=%b",
                     tag, bus.done, bus.end_trans, bus.sum_money, bus.price, bus.item_select,
                     bus.change, bus.change_valid, bus.coin_reject,
                     done, et, sum, price, isel, chg, cv, rej);
        end
    endtask

    initial begin
        //   st iv it money  dm cn cb | done et sum price isel chg cv rej
        // Purchase: item 3 (25), coins 20+10, change 5
        add(1, 0, 0, 3'b000, 0, 0, 0,   0, 0,   0,  0, 0,  0, 0, 0);
        add(0, 1, 3, 3'b000, 0, 0, 0,   0, 0,   0, 25, 3,  0, 0, 0);
        add(0, 0, 0, 3'b100, 0, 0, 0,   0, 0,  20, 25, 3,  0, 0, 0);
        add(0, 0, 0, 3'b010, 0, 0, 0,   0, 0,  30, 25, 3,  0, 0, 0);
        add(0, 0, 0, 3'b000, 1, 0, 0,   1, 0,  30, 25, 3,  0, 0, 0);
        add(0, 0, 0, 3'b000, 0, 0, 0,   0, 1,   5, 25, 3,  5, 1, 0);
        add(0, 0, 0, 3'b000, 0, 0, 0,   0, 0,   0,  0, 0,  0, 0, 0);
        // Multi-buy: item 1 (15), coins 20+20, keep 25, item 0 (10), change 15
        add(1, 0, 0, 3'b000, 0, 0, 0,   0, 0,   0,  0, 0,  0, 0, 0);
        add(0, 1, 1, 3'b000, 0, 0, 0,   0, 0,   0, 15, 1,  0, 0, 0);
        add(0, 0, 0, 3'b100, 0, 0, 0,   0, 0,  20, 15, 1,  0, 0, 0);
        add(0, 0, 0, 3'b100, 0, 0, 0,   0, 0,  40, 15, 1,  0, 0, 0);
        add(0, 0, 0, 3'b000, 1, 0, 0,   1, 0,  40, 15, 1,  0, 0, 0);
        add(0, 0, 0, 3'b000, 0, 0, 1,   0, 0,  25, 15, 1,  0, 0, 0);
        add(0, 1, 0, 3'b000, 0, 0, 0,   0, 0,  25, 10, 0,  0, 0, 0);
        add(0, 0, 0, 3'b000, 1, 0, 0,   1, 0,  25, 10, 0,  0, 0, 0);
        add(0, 0, 0, 3'b000, 0, 0, 0,   0, 1,  15, 10, 0, 15, 1, 0);
        add(0, 0, 0, 3'b000, 0, 0, 0,   0, 0,   0,  0, 0,  0, 0, 0);
        // Insufficient credit, then cancel: item 2 (20), coin 10
        add(1, 0, 0, 3'b000, 0, 0, 0,   0, 0,   0,  0, 0,  0, 0, 0);
        add(0, 1, 2, 3'b000, 0, 0, 0,   0, 0,   0, 20, 2,  0, 0, 0);
        add(0, 0, 0, 3'b010, 0, 0, 0,   0, 0,  10, 20, 2,  0, 0, 0);
        add(0, 0, 0, 3'b000, 1, 0, 0,   0, 0,  10, 20, 2,  0, 0, 0);
        add(0, 0, 0, 3'b000, 0, 1, 0,   0, 1,  10, 20, 2, 10, 1, 0);
        add(0, 0, 0, 3'b000, 0, 0, 0,   0, 0,   0,  0, 0,  0, 0, 0);
        // Reject cases: coin in IDLE, multi-bit coins, coin in cancel cycle; coin in SELECT accepted
        add(0, 0, 0, 3'b001, 0, 0, 0,   0, 0,   0,  0, 0,  0, 0, 1);
        add(1, 0, 0, 3'b000, 0, 0, 0,   0, 0,   0,  0, 0,  0, 0, 0);
        add(0, 0, 0, 3'b011, 0, 0, 0,   0, 0,   0,  0, 0,  0, 0, 1);
        add(0, 0, 0, 3'b001, 0, 0, 0,   0, 0,   5,  0, 0,  0, 0, 0);
        add(0, 1, 3, 3'b010, 0, 0, 0,   0, 0,  15, 25, 3,  0, 0, 0);
        add(0, 0, 0, 3'b110, 0, 0, 0,   0, 0,  15, 25, 3,  0, 0, 1);
        add(0, 0, 0, 3'b001, 0, 1, 0,   0, 1,  15, 25, 3, 15, 1, 1);
        add(0, 0, 0, 3'b000, 0, 0, 0,   0, 0,   0,  0, 0,  0, 0, 0);
        // Zero-credit cancel still produces a change pulse of 0
        add(1, 0, 0, 3'b000, 0, 0, 0,   0, 0,   0,  0, 0,  0, 0, 0);
        add(0, 0, 0, 3'b000, 0, 1, 0,   0, 1,   0,  0, 0,  0, 1, 0);
        add(0, 0, 0, 3'b000, 0, 0, 0,   0, 0,   0,  0, 0,  0, 0, 0);

        idle_in();
        #12;
        chk("reset_state", 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].iv, vecs[i].item, vecs[i].money,
                  vecs[i].dm, vecs[i].cn, vecs[i].cb);
            step();
            chk($sformatf("vec%0d", i), vecs[i].done, vecs[i].et, vecs[i].sum, vecs[i].price,
                vecs[i].isel, vecs[i].chg, vecs[i].cv, vecs[i].rej);
        end
        idle_in();

        // Overflow: build 250, coin 10 refused, coin 5 reaches 255 exactly
        drive(1, 0, 0, 3'b000, 0, 0, 0); step();
        drive(0, 1, 0, 3'b000, 0, 0, 0); step();
        drive(0, 0, 0, 3'b100, 0, 0, 0); repeat (12) step();
        drive(0, 0, 0, 3'b010, 0, 0, 0); step();
        chk("ovf_sum250", 0, 0, 250, 10, 0, 0, 0, 0);
        step();
        chk("ovf_reject", 0, 0, 250, 10, 0, 0, 0, 1);
        idle_in(); step();
        chk("ovf_pulse_end", 0, 0, 250, 10, 0, 0, 0, 0);
        drive(0, 0, 0, 3'b001, 0, 0, 0); step();
        chk("ovf_max255", 0, 0, 255, 10, 0, 0, 0, 0);
        drive(0, 0, 0, 3'b000, 0, 1, 0); step();
        chk("ovf_refund", 0, 1, 255, 10, 0, 255, 1, 0);
        idle_in(); step();
        chk("ovf_idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // Timeout: coin 5 then 255 idle cycles
        drive(1, 0, 0, 3'b000, 0, 0, 0); step();
        drive(0, 1, 2, 3'b000, 0, 0, 0); step();
        drive(0, 0, 0, 3'b001, 0, 0, 0); step();
        idle_in();
        repeat (254) step();
        chk("tmo_not_yet", 0, 0, 5, 20, 2, 0, 0, 0);
        step();
        chk("tmo_refund", 0, 1, 5, 20, 2, 5, 1, 0);
        step();
        chk("tmo_idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-COLLECT with 15 credit, then a clean purchase
        drive(1, 0, 0, 3'b000, 0, 0, 0); step();
        drive(0, 1, 1, 3'b000, 0, 0, 0); step();
        drive(0, 0, 0, 3'b010, 0, 0, 0); step();
        drive(0, 0, 0, 3'b001, 0, 0, 0); step();
        idle_in();
        chk("rst_pre_sum15", 0, 0, 15, 15, 1, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1 chk("rst_async_clear", 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("rst_no_refund", 0, 0, 0, 0, 0, 0, 0, 0);
        #3 reset_n = 1'b1;
        step();
        drive(1, 0, 0, 3'b000, 0, 0, 0); step();
        drive(0, 1, 0, 3'b000, 0, 0, 0); step();
        chk("rst_new_select", 0, 0, 0, 10, 0, 0, 0, 0);
        drive(0, 0, 0, 3'b010, 0, 0, 0); step();
        drive(0, 0, 0, 3'b000, 1, 0, 0); step();
        chk("rst_new_done", 1, 0, 10, 10, 0, 0, 0, 0);
        idle_in(); step();
        chk("rst_new_change0", 0, 1, 0, 10, 0, 0, 1, 0);
        step();
        chk("rst_new_idle", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_param.md
VEND_CTRL_PARAM -- requirements
Module: vend_ctrl_param

Interface
REQ-001 SHALL have one clock and one reset: clock is clk, reset is reset_n, asynchronous and active-low.
REQ-002 Parameters (name, default, meaning), one per line:
  N_ITEMS  4  number of selectable items
  ITEM_W  2  item index width, at least clog2(N_ITEMS)
  MONEY_W  8  credit, price and change width
  DENOM0 / DENOM1 / DENOM2  5 / 10 / 20  values of coin strobes money[0] / money[1] / money[2]
  PRICE_TABLE  {8'd25,8'd20,8'd15,8'd10}  packed prices; item i at bits [i*MONEY_W +: MONEY_W]
  TIMEOUT  255  idle cycles before auto-cancel
REQ-003 Ports (name, direction, width, meaning):
  clk  in  1  clock
  reset_n  in  1  async active-low reset
  start  in  1  begin transaction
  item_valid  in  1  item_in is valid
  item_in  in  ITEM_W  requested item
  money  in  3  one-hot coin strobe, one cycle per coin
  done_money  in  1  customer finished inserting coins
  cancel  in  1  abort and refund
  continue_buy  in  1  keep credit for another item
  done  out  1  item dispensed pulse
  end_trans  out  1  transaction-complete pulse
  sum_money  out  MONEY_W  current credit
  price  out  MONEY_W  price of the latched item
  item_select  out  ITEM_W  latched item
  change  out  MONEY_W  refund amount, valid with change_valid, else 0
  change_valid  out  1  refund pulse
  coin_reject  out  1  coin not credited pulse

Function
REQ-004 SHALL implement the states IDLE, SELECT, COLLECT, DISPENSE and CHANGE; state encoding is free; all outputs SHALL be registered or decoded from the state register only.
REQ-005 IDLE: start=1 -> SELECT; every other input is ignored.
REQ-006 SELECT: item_valid=1 with item_in<N_ITEMS -> latch item_select, load price from PRICE_TABLE, go to COLLECT; item_in>=N_ITEMS is ignored and the FSM stays in SELECT.
REQ-007 COLLECT, exactly one money bit set: sum_money += that denomination on the next edge.
REQ-008 COLLECT, money=0: no effect.
REQ-009 COLLECT, more than one money bit set: coin_reject pulses for 1 cycle; credit is unchanged.
REQ-010 Coin whose addition would exceed 2^MONEY_W-1: coin_reject pulses; credit is unchanged (no wrap).
REQ-011 Coin in SELECT: credit is accepted as in COLLECT. Coin in IDLE, DISPENSE or CHANGE: coin_reject pulses.
REQ-012 COLLECT: done_money=1 with sum_money>=price -> DISPENSE; with sum_money<price it is ignored and the FSM stays in COLLECT.
REQ-013 cancel=1 in SELECT or COLLECT -> CHANGE. cancel has priority over done_money and item_valid. A coin arriving in the cancel cycle is rejected.
REQ-014 Timeout counter clears on entry to SELECT or COLLECT and on any accepted coin or item; reaching TIMEOUT cycles -> behaves exactly as cancel.
REQ-015 DISPENSE lasts 1 cycle with done=1.
REQ-016 On exit from DISPENSE: sum_money -= price. If continue_buy=1 in that cycle -> SELECT with the remaining credit kept; otherwise -> CHANGE.
REQ-017 CHANGE lasts 1 cycle: change_valid=1, end_trans=1, change=sum_money.
REQ-018 On exit from CHANGE: sum_money, price and item_select are cleared to 0; next state is IDLE.
REQ-019 Latency: done is high in cycle N+1 for done_money sampled at cycle N. change_valid is high in cycle N+1 after a cancel, timeout or DISPENSE exit at cycle N.
REQ-020 CHANGE with zero credit still pulses change_valid with change=0.

Reset
REQ-021 reset_n=0 SHALL, asynchronously: set state to IDLE; set every output to 0 (done, end_trans, sum_money, price, item_select, change, change_valid, coin_reject); clear the timeout counter.
REQ-022 Reset mid-transaction discards credit without a change_valid pulse; operation resumes on the first clk edge after reset_n deasserts.

Verification
REQ-023 Purchase: start; item 3 (25); coins 20, 10 (sum 30); done_money -> done pulse; continue_buy=0 -> change_valid, change=5, end_trans, sum 0.
REQ-024 Multi-buy: item 1 (15); coins 20, 20 (sum 40); done_money with continue_buy=1 -> SELECT, sum 25; item 0 (10); done_money, continue_buy=0 -> change=15.
REQ-025 Insufficient then cancel: item 2 (20); coin 10; done_money -> no done, stays in COLLECT; cancel -> change=10, end_trans.
REQ-026 Reject cases: money=3'b011 -> coin_reject 1 cycle, sum unchanged; sum 250 plus coin 10 -> coin_reject, sum stays 250.
REQ-027 Timeout: coin 5, then 255 idle cycles -> change_valid, change=5, end_trans, then IDLE.
REQ-028 Reset: reset_n low in COLLECT with sum 15 -> all outputs 0 immediately, no change_valid; then a new purchase completes normally.
